pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
Per-core next-PC controller in front of instruction memory.
- Holds the fetch PC and advances it by one each cycle.
- Computes branch targets internally as a PC-relative add.
- Sequences redirect and flush bubbles, stall, halt and restart.
- Sits between the execute stage's branch resolution and the instruction-memory address port.

Parameters:
- INST_ADDR_WIDTH, 9: width of every PC/offset/target bus.
- RESET_PC, 0: pc_out value after reset.
- FLUSH_CYCLES, 2: bubble cycles after a taken branch. Legal range 1..15.

Ports:
- clk  input  1: sole clock, rising edge.
- rst_n  input  1: synchronous, active-low reset.
- start  input  1: begin fetching at start_pc (honoured in IDLE/HALT only).
- start_pc  input  INST_ADDR_WIDTH: restart address.
- stall  input  1: hold current PC.
- branch_valid  input  1: branch resolved this cycle.
- branch_taken  input  1: qualifies branch_valid.
- branch_pc  input  INST_ADDR_WIDTH: PC of the branch instruction.
- branch_offset  input  INST_ADDR_WIDTH: two's-complement offset.
- halt_req  input  1: stop fetching.
- pc_out  output  INST_ADDR_WIDTH: fetch address (registered).
- pc_valid  output  1: pc_out is a real fetch this cycle.
- flush  output  1: younger in-flight instructions must be discarded.
- halted  output  1: in HALT state.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - state=IDLE, pc_out=RESET_PC, pc_valid=0, flush=0, halted=0, flush counter=0.
  - Reset overrides every other input.
  - Mid-operation reset takes effect the next edge; any pending redirect is dropped.
- All outputs are registered. Every decision below is visible one cycle after the inputs are sampled.
- Target arithmetic:
  - target = branch_pc + branch_offset, truncated to INST_ADDR_WIDTH (modulo 2^W; wrap allowed in both directions).
  - Sequential increment also wraps: 2^W-1 -> 0.
- States:
  - IDLE: pc_valid=0. start=1 -> RUN, pc_out=start_pc, pc_valid=1. Other inputs are ignored.
  - RUN: pc_valid=1. Per-cycle priority is halt_req > taken branch > stall > increment.
    - halt_req -> HALT: pc_valid=0, halted=1, pc_out held.
    - branch_valid & branch_taken -> FLUSH: pc_out=target, pc_valid=0, flush=1, counter=FLUSH_CYCLES-1. The branch wins even if stall=1.
    - stall: pc_out held, pc_valid stays 1.
    - Otherwise pc_out=pc_out+1.
    - branch_valid with branch_taken=0 has no effect.
    - start is ignored.
  - FLUSH: flush=1, pc_valid=0, pc_out held at target.
    - stall, start and branch_valid are ignored.
    - Counter decrements each cycle. When the counter is 0 -> RUN: flush=0, pc_valid=1, pc_out=target (first fetch of target).
    - halt_req -> HALT immediately: flush=0; pc_out keeps target, so a later start overrides it.
  - HALT: halted=1, pc_valid=0. start=1 -> RUN at start_pc, halted=0. halt_req is ignored.
- Resulting bubble: exactly FLUSH_CYCLES cycles with pc_valid=0 between the last pre-branch fetch and the target fetch.
- Simultaneous start+halt_req in HALT/IDLE: start wins.

Optional Feature:
ABSOLUTE_BRANCH_EN
- Defined: target = branch_offset; branch_pc is ignored (absolute jump encoding). Everything else is unchanged.
- Undefined: PC-relative target as above.

Test Plan:
- Reset then start with start_pc=0x010, no stall -> pc_out 0x010, 0x011, 0x012 on consecutive cycles, pc_valid=1 from the first cycle after start.
- RUN at pc 0x020, branch_valid=1, branch_taken=1, branch_pc=0x01E, offset=0x1F6 (-10), FLUSH_CYCLES=2 -> flush=1 and pc_valid=0 for 2 cycles, then pc_out=0x014 with pc_valid=1. Not-taken branch -> increments continue.
- Wrap cases:
  - pc at 0x1FF -> next pc_out=0x000.
  - branch_pc=0x1FC with offset=0x008 -> target 0x004.
  - With ABSOLUTE_BRANCH_EN, same stimulus -> target 0x008.
- Stall for 3 cycles at 0x040, with a taken branch in the 2nd stall cycle -> branch wins; redirect and flush follow; stall ignored during FLUSH.
- halt_req during FLUSH -> halted=1 next cycle, flush=0. Then start with start_pc=0x100 -> RUN at 0x100, halted=0. halt_req in IDLE -> no effect.
- rst_n=0 in the middle of FLUSH -> next cycle state IDLE, pc_out=RESET_PC, flush=0, pc_valid=0. start while rst_n=0 -> ignored.

Source files
------------

// File: rtl/pc_sequencer_if.sv
// Fetch-control bundle between execute/control logic and the next-PC sequencer.
// The master drives control and branch resolution; the slave returns the fetch address and status.
interface pc_sequencer_if #(
  parameter int INST_ADDR_WIDTH = 9
);
  logic                       start;
  logic [INST_ADDR_WIDTH-1:0] start_pc;
  logic                       stall;
  logic                       branch_valid;
  logic                       branch_taken;
  logic [INST_ADDR_WIDTH-1:0] branch_pc;
  logic [INST_ADDR_WIDTH-1:0] branch_offset;
  logic                       halt_req;
  logic [INST_ADDR_WIDTH-1:0] pc_out;
  logic                       pc_valid;
  logic                       flush;
  logic                       halted;

  modport master (
    output start, start_pc, stall, branch_valid, branch_taken,
           branch_pc, branch_offset, halt_req,
    input  pc_out, pc_valid, flush, halted
  );

  modport slave (
    input  start, start_pc, stall, branch_valid, branch_taken,
           branch_pc, branch_offset, halt_req,
    output pc_out, pc_valid, flush, halted
  );
endinterface

// File: rtl/pc_sequencer.sv
// Next-PC sequencer: increment, branch redirect with flush bubbles, stall, halt and restart.
// Optional macro ABSOLUTE_BRANCH_EN: branch target is branch_offset itself (branch_pc ignored).
//
// state | meaning
// IDLE  | out of reset, not fetching, waiting for start
// RUN   | fetching; pc_out advances unless stalled or redirected
// FLUSH | redirect bubble; pc_out holds the target, counter runs down
// HALT  | stopped on request, waiting for start
module pc_sequencer #(
  parameter int INST_ADDR_WIDTH = 9,
  parameter int RESET_PC        = 0,
  parameter int FLUSH_CYCLES    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  pc_sequencer_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    HALT  = 2'd3
  } state_t;

  localparam logic [INST_ADDR_WIDTH-1:0] RESET_PC_V = INST_ADDR_WIDTH'(RESET_PC);
  localparam logic [3:0]                 FLUSH_INIT = 4'(FLUSH_CYCLES - 1);

  state_t                     state_q, state_d;
  logic [INST_ADDR_WIDTH-1:0] pc_q, pc_d;
  logic                       pc_valid_q, pc_valid_d;
  logic                       flush_q, flush_d;
  logic                       halted_q, halted_d;
  logic [3:0]                 cnt_q, cnt_d;
  logic [INST_ADDR_WIDTH-1:0] target;

`ifdef ABSOLUTE_BRANCH_EN
  logic unused_branch_pc;
  assign unused_branch_pc = ^bus.branch_pc;
  assign target = bus.branch_offset;
`else
  // Modulo 2^W add: wraps in both directions for two's-complement offsets.
  assign target = bus.branch_pc + bus.branch_offset;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC_V;
      pc_valid_q <= 1'b0;
      flush_q    <= 1'b0;
      halted_q   <= 1'b0;
      cnt_q      <= 4'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pc_valid_q <= pc_valid_d;
      flush_q    <= flush_d;
      halted_q   <= halted_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pc_valid_d = 1'b0;
    flush_d    = 1'b0;
    halted_d   = 1'b0;
    cnt_d      = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d    = RUN;
          pc_d       = bus.start_pc;
          pc_valid_d = 1'b1;
        end
      end
      RUN: begin
        pc_valid_d = 1'b1;
        if (bus.halt_req) begin
          state_d    = HALT;
          pc_valid_d = 1'b0;
          halted_d   = 1'b1;
        end else if (bus.branch_valid && bus.branch_taken) begin
          state_d    = FLUSH;
          pc_d       = target;
          pc_valid_d = 1'b0;
          flush_d    = 1'b1;
          cnt_d      = FLUSH_INIT;
        end else if (!bus.stall) begin
          pc_d = pc_q + 1'b1;
        end
      end
      FLUSH: begin
        if (bus.halt_req) begin
          state_d  = HALT;
          halted_d = 1'b1;
        end else if (cnt_q == 4'd0) begin
          // pc_q already holds the target, so it becomes the first real fetch.
          state_d    = RUN;
          pc_valid_d = 1'b1;
        end else begin
          cnt_d   = cnt_q - 4'd1;
          flush_d = 1'b1;
        end
      end
      HALT: begin
        halted_d = 1'b1;
        if (bus.start) begin
          state_d    = RUN;
          pc_d       = bus.start_pc;
          pc_valid_d = 1'b1;
          halted_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.pc_out   = pc_q;
  assign bus.pc_valid = pc_valid_q;
  assign bus.flush    = flush_q;
  assign bus.halted   = halted_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: each driven cycle queues the expected registered
// outputs, which are popped and compared one cycle later.
module tb_pc_sequencer;

  localparam int W = 9;

`ifdef ABSOLUTE_BRANCH_EN
  localparam logic [W-1:0] T_A = 9'h1F6;
  localparam logic [W-1:0] T_B = 9'h008;
  localparam logic [W-1:0] T_C = 9'h010;
  localparam logic [W-1:0] T_D = 9'h004;
  localparam logic [W-1:0] T_E = 9'h1FF;
`else
  localparam logic [W-1:0] T_A = 9'h014;
  localparam logic [W-1:0] T_B = 9'h004;
  localparam logic [W-1:0] T_C = 9'h050;
  localparam logic [W-1:0] T_D = 9'h064;
  localparam logic [W-1:0] T_E = 9'h100;
`endif

  typedef struct {
    string        tag;
    logic [W-1:0] pc;
    logic         valid;
    logic         flush;
    logic         halted;
  } exp_t;

  logic clk;
  logic rst_n;
  int   tests_run;
  int   tests_failed;
  exp_t sb_q[$];

  pc_sequencer_if #(.INST_ADDR_WIDTH(W)) bus ();

  pc_sequencer #(
    .INST_ADDR_WIDTH(W),
    .RESET_PC       (0),
    .FLUSH_CYCLES   (2)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Drive one cycle of inputs, queue the expected post-edge outputs, then score them.
  task automatic step(input string tag, input logic rst, input logic st, input logic [W-1:0] spc,
                      input logic stl, input logic bv, input logic bt, input logic [W-1:0] bpc,
                      input logic [W-1:0] boff, input logic hr, input logic [W-1:0] epc,
                      input logic ev, input logic ef, input logic eh);
    exp_t e;
    rst_n             = rst;
    bus.start         = st;
    bus.start_pc      = spc;
    bus.stall         = stl;
    bus.branch_valid  = bv;
    bus.branch_taken  = bt;
    bus.branch_pc     = bpc;
    bus.branch_offset = boff;
    bus.halt_req      = hr;
    e.tag = tag; e.pc = epc; e.valid = ev; e.flush = ef; e.halted = eh;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, ".pc"},     32'(bus.pc_out),   32'(e.pc));
    check({e.tag, ".valid"},  32'(bus.pc_valid), 32'(e.valid));
    check({e.tag, ".flush"},  32'(bus.flush),    32'(e.flush));
    check({e.tag, ".halted"}, 32'(bus.halted),   32'(e.halted));
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    rst_n = 1'b0;
    bus.start = 1'b0; bus.start_pc = '0; bus.stall = 1'b0; bus.branch_valid = 1'b0;
    bus.branch_taken = 1'b0; bus.branch_pc = '0; bus.branch_offset = '0; bus.halt_req = 1'b0;
    #2;

    //    tag          rst st  spc     stl bv bt bpc     boff    hr  exp_pc     v  f  h
    step("rst0",       0, 1, 9'h055, 0, 0, 0, 9'h000, 9'h000, 0, 9'h000,    0, 0, 0);
    step("rst1",       0, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 9'h000,    0, 0, 0);
    step("idle_halt",  1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 1, 9'h000,    0, 0, 0);
    step("start",      1, 1, 9'h010, 0, 0, 0, 9'h000, 9'h000, 0, 9'h010,    1, 0, 0);
    step("inc1",       1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 9'h011,    1, 0, 0);
    step("inc2",       1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 9'h012,    1, 0, 0);
    step("not_taken",  1, 0, 9'h000, 0, 1, 0, 9'h01E, 9'h1F6, 0, 9'h013,    1, 0, 0);
    step("run_start",  1, 1, 9'h020, 0, 0, 0, 9'h000, 9'h000, 0, 9'h014,    1, 0, 0);
    step("halt1",      1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 1, 9'h014,    0, 0, 1);
    step("st_and_hr",  1, 1, 9'h020, 0, 0, 0, 9'h000, 9'h000, 1, 9'h020,    1, 0, 0);
    step("br_neg",     1, 0, 9'h000, 0, 1, 1, 9'h01E, 9'h1F6, 0, T_A,       0, 1, 0);
    step("fl_stall",   1, 1, 9'h077, 1, 1, 1, 9'h000, 9'h033, 0, T_A,       0, 1, 0);
    step("tgt_fetch",  1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, T_A,       1, 0, 0);
    step("tgt_inc",    1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, W'(T_A+1), 1, 0, 0);
    step("halt2",      1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 1, W'(T_A+1), 0, 0, 1);
    step("start_1fe",  1, 1, 9'h1FE, 0, 0, 0, 9'h000, 9'h000, 0, 9'h1FE,    1, 0, 0);
    step("inc_1ff",    1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 9'h1FF,    1, 0, 0);
    step("inc_wrap",   1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 9'h000,    1, 0, 0);
    step("br_wrap",    1, 0, 9'h000, 0, 1, 1, 9'h1FC, 9'h008, 0, T_B,       0, 1, 0);
    step("br_wrap_f",  1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, T_B,       0, 1, 0);
    step("br_wrap_t",  1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, T_B,       1, 0, 0);
    step("halt3",      1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 1, T_B,       0, 0, 1);
    step("start_040",  1, 1, 9'h040, 0, 0, 0, 9'h000, 9'h000, 0, 9'h040,    1, 0, 0);
    step("stall1",     1, 0, 9'h000, 1, 0, 0, 9'h000, 9'h000, 0, 9'h040,    1, 0, 0);
    step("stall2_br",  1, 0, 9'h000, 1, 1, 1, 9'h040, 9'h010, 0, T_C,       0, 1, 0);
    step("stall3_fl",  1, 0, 9'h000, 1, 0, 0, 9'h000, 9'h000, 0, T_C,       0, 1, 0);
    step("stall_tgt",  1, 0, 9'h000, 1, 0, 0, 9'h000, 9'h000, 0, T_C,       1, 0, 0);
    step("stall_inc",  1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, W'(T_C+1), 1, 0, 0);
    step("br_h",       1, 0, 9'h000, 0, 1, 1, 9'h060, 9'h004, 0, T_D,       0, 1, 0);
    step("fl_halt",    1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 1, T_D,       0, 0, 1);
    step("halt_again", 1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 1, T_D,       0, 0, 1);
    step("start_100",  1, 1, 9'h100, 0, 0, 0, 9'h000, 9'h000, 0, 9'h100,    1, 0, 0);
    step("inc_101",    1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 9'h101,    1, 0, 0);
    step("br_r",       1, 0, 9'h000, 0, 1, 1, 9'h101, 9'h1FF, 0, T_E,       0, 1, 0);
    step("fl_reset",   0, 1, 9'h0AA, 0, 0, 0, 9'h000, 9'h000, 0, 9'h000,    0, 0, 0);
    step("post_rst",   1, 0, 9'h000, 0, 0, 0, 9'h000, 9'h000, 0, 9'h000,    0, 0, 0);
    step("start_0aa",  1, 1, 9'h0AA, 0, 0, 0, 9'h000, 9'h000, 0, 9'h0AA,    1, 0, 0);
    step("halt_vs_br", 1, 0, 9'h000, 0, 1, 1, 9'h000, 9'h020, 1, 9'h0AA,    0, 0, 1);

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
